// File: rtl/cpu_divider.sv
// cpu_divider: iterative restoring divide/remainder unit for RV32M DIV, DIVU, REM, REMU.
//   Ports: clk, reset (async, active-high), start, op (00 DIV, 01 DIVU, 10 REM, 11 REMU),
//          a (dividend), b (divisor), busy, done (one-cycle pulse), result.
//   Optional macro CPU_DIVIDER_FAST_PATH_EN: divide-by-zero and signed overflow skip RUN.
module cpu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic             r_rsel, r_qneg, r_rneg, r_dz, r_ovf, r_done;
    logic [WIDTH-1:0] r_a, r_quo, r_rem, r_div, r_result;
    logic             w_signed, w_dz, w_ovf, w_fast;
    logic [WIDTH-1:0] w_a_mag, w_b_mag, w_q, w_r;
    logic [WIDTH:0]   w_shift, w_diff;
    assign w_signed = ~op[0];
    assign w_dz     = b == '0;
    assign w_ovf    = w_signed && a == MSB && b == '1;
    assign w_a_mag  = (w_signed && a[WIDTH-1]) ? -a : a;
    assign w_b_mag  = (w_signed && b[WIDTH-1]) ? -b : b;
`ifdef CPU_DIVIDER_FAST_PATH_EN
    assign w_fast = w_dz | w_ovf;
`else
    assign w_fast = 1'b0;
`endif
    // Remainder and quotient form one shift register; the quotient MSB feeds the remainder.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_div};
    // Special cases override whatever the iteration left behind.
    assign w_q = r_dz ? '1 : r_ovf ? MSB : r_qneg ? -r_quo : r_quo;
    assign w_r = r_dz ? r_a : r_ovf ? '0 : r_rneg ? -r_rem : r_rem;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? (w_fast ? FINISH : RUN) : IDLE;
            RUN:     w_next = (r_cnt == '0) ? FINISH : RUN;
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_rsel   <= 1'b0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
            r_a      <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_rsel <= op[1];
                    r_a    <= a;
                    r_dz   <= w_dz;
                    r_ovf  <= w_ovf;
                    r_qneg <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    r_rneg <= w_signed & a[WIDTH-1];
                    r_quo  <= w_a_mag;
                    r_rem  <= '0;
                    r_div  <= w_b_mag;
                    r_cnt  <= CW'(WIDTH-1);
                end
                RUN: begin
                    r_quo <= {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
                    r_rem <= w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
                    r_cnt <= r_cnt - 1'b1;
                end
                FINISH: begin
                    r_result <= r_rsel ? w_r : w_q;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end
    assign busy   = r_state != IDLE;
    assign done   = r_done;
    assign result = r_result;
endmodule

// File: tb/tb_cpu_divider.sv
// tb_cpu_divider: randomized self-checking bench for cpu_divider against an arithmetic reference.
module tb_cpu_divider;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] result;
    int n_tests = 0;
    int n_fail  = 0;

    cpu_divider #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        if (y == 0) return o[1] ? x : 32'hFFFF_FFFF;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
        if (!o[0]) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return o[1] ? 32'(sx % sy) : 32'(sx / sy);
        end
        return o[1] ? x % y : x / y;
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
`ifdef CPU_DIVIDER_FAST_PATH_EN
        if (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) return 2;
`endif
        return 34;
    endfunction

    // Caller positions time before the start edge; returns #1 into the done cycle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] res, output int lat, output int bcnt);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1; bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        if (!done) check("timeout", 32'(lat), 32'(exp_lat(o, x, y)));
        check("busy_low_in_done", {31'b0, busy}, 32'h0);
        res = result;
    endtask

    task automatic op_check(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] res;
        int lat, bcnt;
        run_op(o, x, y, res, lat, bcnt);
        check({tag, "_result"}, res, model(o, x, y));
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat(o, x, y)));
        check({tag, "_busy_cycles"}, 32'(bcnt), 32'(exp_lat(o, x, y) - 1));
    endtask

    initial begin
        logic [31:0] res, x, y;
        logic [1:0]  o;
        int lat, bcnt, dcnt;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_done", {31'b0, done}, 32'h0);
        check("reset_result", result, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        op_check("divu_100_7", 2'b01, 32'd100, 32'd7);
        @(negedge clk);
        op_check("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
        @(negedge clk);
        op_check("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2);
        @(negedge clk);
        op_check("div_by_zero", 2'b00, 32'd5, 32'd0);
        @(negedge clk);
        op_check("remu_by_zero", 2'b11, 32'd5, 32'd0);
        @(negedge clk);
        op_check("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        @(negedge clk);
        op_check("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        // Start in the done cycle must be accepted.
        @(negedge clk);
        run_op(2'b01, 32'd1000, 32'd9, res, lat, bcnt);
        check("b2b_first", res, 32'd111);
        op_check("b2b_second", 2'b00, 32'hFFFF_FF9C, 32'd7);
        // A start while busy is ignored.
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; a = 32'd9; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 6;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("ignored_start_result", result, 32'd14);
        check("ignored_start_latency", 32'(lat), 32'd34);
        // Reset mid-operation aborts it with no later done.
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_done", {31'b0, done}, 32'h0);
        check("abort_result", result, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        dcnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        check("abort_no_done", 32'(dcnt), 32'h0);
        // Randomized operands, biased toward the special cases and small divisors.
        for (int i = 0; i < 150; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'h0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: y = $urandom_range(1, 15);
                3: y = -$urandom_range(1, 15);
                4: x = $urandom_range(0, 50);
                default: ;
            endcase
            @(negedge clk);
            op_check("rand", o, x, y);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    always @(negedge clk) begin
        if (busy && done) check("busy_done_overlap", 32'h1, 32'h0);
    end
endmodule

// File: doc/cpu_divider.md
Name: cpu_divider

Overview:
- Iterative multi-cycle divide/remainder unit for the RV32M DIV, DIVU, REM and REMU instructions.
- Sits in the execute stage alongside the single-cycle ALU.
- Shares the ALU's operand conventions: 32-bit a = dividend, b = divisor.
- Uses a start/busy/done handshake so the pipeline can stall while the unit works.

Parameters:
- WIDTH, 32, operand and result width. Only 32 is required for RV32; the logic stays generic.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled only while in IDLE.
- op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (equals funct3[1:0]).
- a  input  WIDTH  dividend; captured when start is accepted.
- b  input  WIDTH  divisor; captured when start is accepted.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; result is valid in this cycle.
- result  output  WIDTH  quotient or remainder; held until the next done.

Behaviour:
- Reset, asynchronous, active-high:
  - state = IDLE, busy = 0, done = 0, result = 0, internal registers = 0.
  - Reset during RUN or FINISH aborts the operation; no done pulse follows.
- States:
  - IDLE: busy = 0. If start = 1 at an edge:
    - capture op, a, b;
    - for signed ops (DIV, REM), record the quotient sign (a[WIDTH-1] ^ b[WIDTH-1]) and the remainder sign (a[WIDTH-1]);
    - load the magnitudes |a| and |b| (raw a and b for unsigned ops);
    - counter = WIDTH-1; go to RUN.
  - RUN: busy = 1. One restoring-division step per cycle:
    - shift the remainder/quotient pair left by 1;
    - trial-subtract the divisor magnitude (WIDTH+1-bit subtraction);
    - if the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set the LSB to 0.
    - When counter == 0, go to FINISH; otherwise decrement counter.
    - Exactly WIDTH RUN cycles.
  - FINISH: busy = 1.
    - Apply sign correction: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
    - Select quotient (DIV/DIVU) or remainder (REM/REMU).
    - Register result, pulse done = 1 for the following cycle, go to IDLE.
- Latency: if start is accepted at edge E0, done is high in the cycle after edge E0+WIDTH+1. That is 34 cycles for WIDTH = 32.
- busy is high from the cycle after E0 through the FINISH cycle. It is low in the cycle done is high, so back-to-back start is allowed in the done cycle.
- start while busy = 1 is ignored; the operation in flight is unaffected.
- Special cases (RISC-V defined, never trap):
  - Divide by zero: quotient = all ones (DIV and DIVU); remainder = a.
  - Signed overflow (a = 0x80000000, b = 0xFFFFFFFF, DIV/REM): quotient = 0x80000000, remainder = 0.
  - Without the fast path, these are detected at capture and override the final result in FINISH. Latency is unchanged.
- result updates only on the done cycle; it is stable at all other times.
- done and busy are never high in the same cycle.

Optional Feature:
- Macro: CPU_DIVIDER_FAST_PATH_EN.
- Defined:
  - In IDLE, if start is accepted and b == 0 or signed overflow is detected, skip RUN and go directly to FINISH with the special-case result.
  - done is then high in the cycle after E0+1, i.e. 2-cycle latency.
  - Normal operands keep full latency.
- Not defined: all operations take WIDTH+2 cycles; results are identical either way.

Test Plan:
- DIVU a = 100, b = 7 -> result = 14; done exactly 34 cycles after the start cycle; busy high for 33 cycles before done.
- REM a = -7 (0xFFFFFFF9), b = 2 -> result = 0xFFFFFFFF (-1).
- DIV a = -7, b = 2 -> result = 0xFFFFFFFD (-3).
- DIV a = 5, b = 0 -> result = 0xFFFFFFFF. REMU a = 5, b = 0 -> result = 5. Latency 34 cycles, or 2 cycles with CPU_DIVIDER_FAST_PATH_EN.
- DIV a = 0x80000000, b = 0xFFFFFFFF -> result = 0x80000000. REM with the same operands -> result = 0.
- DIVU 100/7 started; second start with a = 9, b = 3 pulsed at cycle 5 -> ignored, result = 14.
- Reset asserted at cycle 10 of a DIVU -> busy = 0 and done = 0 immediately, and no done pulse afterwards.
- Start issued in the done cycle -> accepted, and its result is correct.
